fir_wishbone_mc: RTL
====================

Name: fir_wishbone_mc

Overview:
Multi-channel, parametrised Wishbone FIR slave. It is the next generation of the single-channel Wishbone FIR wrapper.
- Holds TAPS coefficients shared by all channels, plus an independent delay line per channel.
- Computes with one time-multiplexed MAC, then applies programmable shift, rounding and saturation.
- Raises an interrupt when a result is ready.
- Sits on the peripheral Wishbone bus as a classic-cycle slave.

Parameters:
DATA_WIDTH, 16, sample/coefficient/result/bus width in bits; must be >= 16.
TAPS, 8, filter length; 2..2^(ADDR_WIDTH-1).
CH, 2, number of independent channels; 1..256.
ADDR_WIDTH, 6, Wishbone word-address width; coefficients start at COEF_BASE = 2^(ADDR_WIDTH-1).

Ports:
clk  in  1  single clock; all state updates on its rising edge.
rst  in  1  asynchronous, active-high reset.
adr_i  in  ADDR_WIDTH  word address.
dat_i  in  DATA_WIDTH  write data.
dat_o  out  DATA_WIDTH  read data, valid while ack_o=1.
we_i  in  1  write enable.
stb_i  in  1  strobe.
cyc_i  in  1  bus cycle.
ack_o  out  1  registered acknowledge.
irq_o  out  1  level interrupt = result_valid & CTRL.ie.

Behaviour:
- Reset state: all registers, coefficients and delay lines are 0. FSM goes to IDLE. ack_o=0, dat_o=0, irq_o=0.
- Bus handshake: an access is accepted on an edge where cyc_i & stb_i & ~ack_o. ack_o is high the following cycle, for exactly one cycle.
  - Back-to-back accesses therefore take 2 cycles each.
  - Register side effects and dat_o capture occur on the accept edge.
  - Unmapped addresses: reads return 0, writes are ignored, both are acked.
- Register map:
  - 0x0 CTRL (rw): bit0 en, bit1 clr (self-clearing), bit2 rnd, bit3 ie.
  - 0x1 STATUS (ro except W1C bits):
    - bit0 busy; bit1 valid.
    - bit2 ovr, W1C: sample dropped.
    - bit3 sat, W1C: result clipped.
    - bit4 cerr, W1C: coefficient write rejected.
    - bits[15:8] channel of the last result.
  - 0x2 SAMPLE (wo): writes a sample to the channel in CHSEL.
  - 0x3 CHSEL (rw): writes of a value >= CH are ignored.
  - 0x4 RESULT (ro): reading clears valid.
  - 0x5 SHIFT (rw): 0..2*DATA_WIDTH-1; writes of larger values are ignored.
  - COEF_BASE+i COEF[i] (rw, signed).
- FSM states IDLE -> MAC -> DONE -> IDLE.
  - Accept edge k, SAMPLE write, IDLE, en=1: shift the sample into position 0 of channel CHSEL's delay line (oldest value dropped). Clear acc, tap index=0, latch channel, go to MAC. busy=1.
  - MAC, edges k+1..k+TAPS: acc += COEF[i]*x[ch][i], i increments. On the edge where i=TAPS-1, go to DONE.
  - DONE, edge k+TAPS+1: compute out and load RESULT; valid=1, busy=0, go to IDLE.
  - busy is therefore high for TAPS+1 cycles. irq_o rises in the cycle after edge k+TAPS+1.
- Arithmetic:
  - Products are signed 2*DATA_WIDTH bits. acc is 2*DATA_WIDTH+clog2(TAPS) bits, so it never wraps.
  - If rnd=1 and SHIFT>0, add 2^(SHIFT-1) before an arithmetic right shift by SHIFT.
  - Saturate to signed DATA_WIDTH; set sat if clipped.
- Boundary conditions:
  - SAMPLE write while busy: dropped, ovr=1, acked.
  - SAMPLE write with en=0: dropped silently.
  - COEF write while busy: discarded, cerr=1. COEF reads are always allowed.
  - clr=1 while IDLE zeroes all delay lines that edge. clr while busy is ignored; the bit still self-clears.
  - RESULT read on the same edge the engine completes: the read returns the old value, and valid remains 1 for the new result.
  - New result while valid is already 1: overwrites the old result, valid stays 1.
  - W1C write and a hardware set on the same edge: the set wins.
  - rst asserted mid-computation: immediate return to the reset state; the in-flight result is lost.

Decomposition:
- Shared package fir_wb_pkg contains:
  - register offsets and STATUS/CTRL bit indices;
  - FSM state encoding;
  - clog2 function and accumulator-width constant.
- One sub-module, fir_mac_engine, contains:
  - delay lines, FSM and MAC;
  - shift/round/saturate logic;
  - start, busy and done interface.
- The top module holds the Wishbone decode, register file, coefficients and irq_o.

Test Plan:
- All COEF=1, SHIFT=0, en=1, ch0 samples 1,2,3 -> RESULT 1,3,6. busy lasts 9 cycles; valid and irq_o (ie=1) follow at accept+9 edges.
- ch0 sample 100, then ch1 sample 5 -> ch1 RESULT=5, STATUS[15:8]=1. Next ch0 sample 0 -> 100.
- COEF0=0xFFFF, others 0, sample 3, SHIFT=1: rnd=1 -> 0xFFFF; rnd=0 -> 0xFFFE. All COEF=0x7FFF, samples 0x7FFF,0x7FFF, SHIFT=0 -> 0x7FFF and sat=1.
- Two SAMPLE writes back-to-back (values 7, 9, COEF0=1) -> RESULT=7, ovr=1. Writing 0x4 to STATUS clears ovr.
- COEF2 write of 0x1234 while busy -> readback unchanged, cerr=1.
- rst pulsed at MAC cycle 3 -> ack_o=0, irq_o=0, STATUS=0, RESULT=0, COEF0 reads 0, next sample computes from a zeroed delay line.

Source files
------------

// File: rtl/fir_wb_pkg.sv
// Shared definitions for the multi-channel Wishbone FIR: register map,
// CTRL/STATUS bit positions, engine state encoding and width helpers.
package fir_wb_pkg;

  localparam int REG_CTRL   = 0;
  localparam int REG_STATUS = 1;
  localparam int REG_SAMPLE = 2;
  localparam int REG_CHSEL  = 3;
  localparam int REG_RESULT = 4;
  localparam int REG_SHIFT  = 5;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 1;
  localparam int CTRL_RND = 2;
  localparam int CTRL_IE  = 3;

  localparam int ST_BUSY   = 0;
  localparam int ST_VALID  = 1;
  localparam int ST_OVR    = 2;
  localparam int ST_SAT    = 3;
  localparam int ST_CERR   = 4;
  localparam int ST_CH_LSB = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } fir_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Index width that never collapses to zero bits for single-entry arrays.
  function automatic int width_of(input int count);
    return (count > 1) ? clog2(count) : 1;
  endfunction

  // Full-precision accumulator: TAPS products of 2*DW bits cannot wrap.
  function automatic int acc_width(input int dw, input int taps);
    return 2 * dw + clog2(taps);
  endfunction

endpackage

// File: rtl/fir_mac_engine.sv
// Per-channel delay lines with a single time-multiplexed MAC, followed by
// shift / round / saturate of the accumulated sum.
module fir_mac_engine
  import fir_wb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int TAPS       = 8,
  parameter int CH         = 2,
  localparam int CHW       = width_of(CH),
  localparam int SHW       = clog2(2 * DATA_WIDTH)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             clr,
  input  logic                             rnd,
  input  logic [DATA_WIDTH-1:0]            sample,
  input  logic [CHW-1:0]                   chan,
  input  logic [SHW-1:0]                   shift,
  input  logic [TAPS-1:0][DATA_WIDTH-1:0]  coef,
  output logic                             busy,
  output logic                             done,
  output logic                             sat,
  output logic [DATA_WIDTH-1:0]            result,
  output logic [CHW-1:0]                   result_ch
);

  localparam int IDXW = clog2(TAPS);
  localparam int ACCW = acc_width(DATA_WIDTH, TAPS);
  localparam int EXTW = ACCW + 1;
  localparam logic signed [EXTW-1:0] MAX_V =
    {{(EXTW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [EXTW-1:0] MIN_V =
    {{(EXTW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  fir_state_e                    state_r, state_nxt_s;
  logic [DATA_WIDTH-1:0]         dline_r [CH][TAPS];
  logic signed [ACCW-1:0]        acc_r;
  logic [IDXW-1:0]               idx_r;
  logic [CHW-1:0]                ch_r;
  logic signed [2*DATA_WIDTH-1:0] prod_s;
  logic                          last_tap_s;
  logic signed [EXTW-1:0]        rnd_s;
  logic signed [EXTW-1:0]        shifted_s;

  assign last_tap_s = (idx_r == IDXW'(TAPS - 1));
  assign prod_s     = $signed(coef[idx_r]) * $signed(dline_r[ch_r][idx_r]);
  assign result_ch  = ch_r;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= state_nxt_s;
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE:  if (start) state_nxt_s = S_MAC; else state_nxt_s = S_IDLE;
      S_MAC:   if (last_tap_s) state_nxt_s = S_DONE; else state_nxt_s = S_MAC;
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State-decoded handshake outputs.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_r)
      S_IDLE:  begin busy = 1'b0; done = 1'b0; end
      S_MAC:   begin busy = 1'b1; done = 1'b0; end
      S_DONE:  begin busy = 1'b1; done = 1'b1; end
      default: begin busy = 1'b0; done = 1'b0; end
    endcase
  end

  // Accumulator, tap index and latched channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= '0;
      idx_r <= '0;
      ch_r  <= '0;
    end else if (state_r == S_IDLE && start) begin
      acc_r <= '0;
      idx_r <= '0;
      ch_r  <= chan;
    end else if (state_r == S_MAC) begin
      acc_r <= acc_r + ACCW'(prod_s);
      idx_r <= idx_r + IDXW'(1);
    end
  end

  // Delay lines: clear-all or shift-in happen only while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CH; c++)
        for (int t = 0; t < TAPS; t++) dline_r[c][t] <= '0;
    end else if (state_r == S_IDLE && clr) begin
      for (int c = 0; c < CH; c++)
        for (int t = 0; t < TAPS; t++) dline_r[c][t] <= '0;
    end else if (state_r == S_IDLE && start) begin
      for (int t = TAPS - 1; t > 0; t--) dline_r[chan][t] <= dline_r[chan][t-1];
      dline_r[chan][0] <= sample;
    end
  end

  // Rounding offset, arithmetic shift and signed saturation.
  always_comb begin
    rnd_s = EXTW'(acc_r);
    if (rnd && shift != '0) rnd_s = EXTW'(acc_r) + (EXTW'(1) <<< (shift - SHW'(1)));
    else                    rnd_s = EXTW'(acc_r);
    shifted_s = rnd_s >>> shift;
    if (shifted_s > MAX_V) begin
      result = MAX_V[DATA_WIDTH-1:0];
      sat    = 1'b1;
    end else if (shifted_s < MIN_V) begin
      result = MIN_V[DATA_WIDTH-1:0];
      sat    = 1'b1;
    end else begin
      result = shifted_s[DATA_WIDTH-1:0];
      sat    = 1'b0;
    end
  end

endmodule

// File: rtl/fir_wishbone_mc.sv
// Classic-cycle Wishbone slave wrapping the multi-channel FIR engine:
// address decode, control/status registers, coefficient store and interrupt.
module fir_wishbone_mc
  import fir_wb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int TAPS       = 8,
  parameter int CH         = 2,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  input  logic                  we_i,
  input  logic                  stb_i,
  input  logic                  cyc_i,
  output logic                  ack_o,
  output logic                  irq_o
);

  localparam int CHW = width_of(CH);
  localparam int SHW = clog2(2 * DATA_WIDTH);
  localparam int CIW = ADDR_WIDTH - 1;
  localparam int TIW = clog2(TAPS);

  logic                            ack_r, irq_r;
  logic [DATA_WIDTH-1:0]           dat_r, result_r, rdata_s, status_s, ctrl_s;
  logic                            en_r, rnd_r, ie_r;
  logic                            valid_r, ovr_r, sat_r, cerr_r;
  logic [CHW-1:0]                  chsel_r, last_ch_r;
  logic [SHW-1:0]                  shift_r;
  logic [TAPS-1:0][DATA_WIDTH-1:0] coef_r;

  logic accept_s, wr_s, rd_s, is_coef_s, coef_hit_s;
  logic [CIW-1:0] off_s, coef_idx_s;
  logic wr_ctrl_s, wr_status_s, wr_sample_s, wr_chsel_s, wr_shift_s, wr_coef_s, rd_result_s;
  logic start_s, clr_s, busy_s, done_s, sat_s;
  logic [DATA_WIDTH-1:0] eng_result_s;
  logic [CHW-1:0] eng_ch_s;
  logic valid_nxt_s, ie_nxt_s;

  assign accept_s   = cyc_i & stb_i & ~ack_r;
  assign wr_s       = accept_s & we_i;
  assign rd_s       = accept_s & ~we_i;
  assign is_coef_s  = adr_i[ADDR_WIDTH-1];
  assign off_s      = adr_i[CIW-1:0];
  assign coef_idx_s = adr_i[CIW-1:0];
  assign coef_hit_s = is_coef_s & ({1'b0, coef_idx_s} < (CIW+1)'(TAPS));

  assign wr_ctrl_s   = wr_s & ~is_coef_s & (off_s == CIW'(REG_CTRL));
  assign wr_status_s = wr_s & ~is_coef_s & (off_s == CIW'(REG_STATUS));
  assign wr_sample_s = wr_s & ~is_coef_s & (off_s == CIW'(REG_SAMPLE));
  assign wr_chsel_s  = wr_s & ~is_coef_s & (off_s == CIW'(REG_CHSEL));
  assign wr_shift_s  = wr_s & ~is_coef_s & (off_s == CIW'(REG_SHIFT));
  assign rd_result_s = rd_s & ~is_coef_s & (off_s == CIW'(REG_RESULT));
  assign wr_coef_s   = wr_s & coef_hit_s;

  assign start_s = wr_sample_s & en_r & ~busy_s;
  assign clr_s   = wr_ctrl_s & dat_i[CTRL_CLR];

  // A completing result re-asserts valid even if RESULT is read on that edge.
  assign valid_nxt_s = done_s | (valid_r & ~rd_result_s);
  assign ie_nxt_s    = wr_ctrl_s ? dat_i[CTRL_IE] : ie_r;

  assign dat_o = dat_r;
  assign ack_o = ack_r;
  assign irq_o = irq_r;

  fir_mac_engine #(
    .DATA_WIDTH (DATA_WIDTH),
    .TAPS       (TAPS),
    .CH         (CH)
  ) u_engine (
    .clk       (clk),
    .rst       (rst),
    .start     (start_s),
    .clr       (clr_s),
    .rnd       (rnd_r),
    .sample    (dat_i),
    .chan      (chsel_r),
    .shift     (shift_r),
    .coef      (coef_r),
    .busy      (busy_s),
    .done      (done_s),
    .sat       (sat_s),
    .result    (eng_result_s),
    .result_ch (eng_ch_s)
  );

  // Assemble CTRL and STATUS read views; clr always reads back as 0.
  always_comb begin
    ctrl_s             = '0;
    ctrl_s[CTRL_EN]    = en_r;
    ctrl_s[CTRL_RND]   = rnd_r;
    ctrl_s[CTRL_IE]    = ie_r;
    status_s           = '0;
    status_s[ST_BUSY]  = busy_s;
    status_s[ST_VALID] = valid_r;
    status_s[ST_OVR]   = ovr_r;
    status_s[ST_SAT]   = sat_r;
    status_s[ST_CERR]  = cerr_r;
    status_s[ST_CH_LSB +: 8] = 8'(last_ch_r);
  end

  // Read data multiplexer.
  always_comb begin
    rdata_s = '0;
    if (is_coef_s) begin
      if (coef_hit_s) rdata_s = coef_r[coef_idx_s[TIW-1:0]];
      else            rdata_s = '0;
    end else begin
      case (off_s)
        CIW'(REG_CTRL):   rdata_s = ctrl_s;
        CIW'(REG_STATUS): rdata_s = status_s;
        CIW'(REG_CHSEL):  rdata_s = DATA_WIDTH'(chsel_r);
        CIW'(REG_RESULT): rdata_s = result_r;
        CIW'(REG_SHIFT):  rdata_s = DATA_WIDTH'(shift_r);
        default:          rdata_s = '0;
      endcase
    end
  end

  // Bus response, control and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_r     <= 1'b0;
      dat_r     <= '0;
      irq_r     <= 1'b0;
      en_r      <= 1'b0;
      rnd_r     <= 1'b0;
      ie_r      <= 1'b0;
      valid_r   <= 1'b0;
      ovr_r     <= 1'b0;
      sat_r     <= 1'b0;
      cerr_r    <= 1'b0;
      chsel_r   <= '0;
      last_ch_r <= '0;
      shift_r   <= '0;
      result_r  <= '0;
    end else begin
      ack_r <= accept_s;
      if (accept_s) dat_r <= we_i ? '0 : rdata_s;
      if (wr_ctrl_s) begin
        en_r  <= dat_i[CTRL_EN];
        rnd_r <= dat_i[CTRL_RND];
      end
      ie_r    <= ie_nxt_s;
      valid_r <= valid_nxt_s;
      irq_r   <= valid_nxt_s & ie_nxt_s;
      ovr_r   <= (wr_sample_s & en_r & busy_s) | (ovr_r  & ~(wr_status_s & dat_i[ST_OVR]));
      sat_r   <= (done_s & sat_s)              | (sat_r  & ~(wr_status_s & dat_i[ST_SAT]));
      cerr_r  <= (wr_coef_s & busy_s)          | (cerr_r & ~(wr_status_s & dat_i[ST_CERR]));
      if (wr_chsel_s && dat_i < DATA_WIDTH'(CH)) chsel_r <= dat_i[CHW-1:0];
      if (wr_shift_s && dat_i < DATA_WIDTH'(2 * DATA_WIDTH)) shift_r <= dat_i[SHW-1:0];
      if (done_s) begin
        result_r  <= eng_result_s;
        last_ch_r <= eng_ch_s;
      end
    end
  end

  // Coefficient store; writes are refused while the MAC is using it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         coef_r <= '0;
    else if (wr_coef_s && !busy_s)   coef_r[coef_idx_s[TIW-1:0]] <= dat_i;
  end

endmodule
